serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl.sv | 93 +++++++++
 tb/tb_serial_sub_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: feeds one operand bit pair per clock (LSB first)
// to an external full-subtractor cell and assembles the difference word and final borrow.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             fs_a,
   output logic             fs_b,
   output logic             fs_bin,
   input  logic             fs_diff,
   input  logic             fs_brr,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one bit pair per cycle through the cell
   // DONE  | one-cycle result-valid pulse; a new start is accepted here too

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             in_run;

   assign in_run = (state == RUN);
   assign fs_a   = in_run & a_sh[0];
   assign fs_b   = in_run & b_sh[0];
   assign fs_bin = in_run & brw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         diff_out   <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  brw   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh     <= a_sh >> 1;
               b_sh     <= b_sh >> 1;
               // concatenate-and-shift keeps this legal for WIDTH = 1
               diff_out <= WIDTH'({fs_diff, diff_out} >> 1);
               brw      <= fs_brr;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) begin
                  borrow_out <= fs_brr;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances, each driving a full-subtractor
// cell model, checked every cycle against an arithmetic result/latency model.
module tb_serial_sub_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // WIDTH = 8 instance
   logic       st8;
   logic [7:0] a8, b8, diff8;
   logic       fa8, fb8, fbin8, fd8, fbr8, bor8, busy8, done8;

   assign fd8  = fa8 ^ fb8 ^ fbin8;
   assign fbr8 = (~fa8 & fb8) | (~(fa8 ^ fb8) & fbin8);

   serial_sub_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .a_in(a8), .b_in(b8),
      .fs_a(fa8), .fs_b(fb8), .fs_bin(fbin8), .fs_diff(fd8), .fs_brr(fbr8),
      .diff_out(diff8), .borrow_out(bor8), .busy(busy8), .done(done8));

   // WIDTH = 1 instance
   logic st1;
   logic [0:0] a1, b1, diff1;
   logic fa1, fb1, fbin1, fd1, fbr1, bor1, busy1, done1;

   assign fd1  = fa1 ^ fb1 ^ fbin1;
   assign fbr1 = (~fa1 & fb1) | (~(fa1 ^ fb1) & fbin1);

   serial_sub_ctrl #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .a_in(a1), .b_in(b1),
      .fs_a(fa1), .fs_b(fb1), .fs_bin(fbin1), .fs_diff(fd1), .fs_brr(fbr1),
      .diff_out(diff1), .borrow_out(bor1), .busy(busy1), .done(done1));

   // Model: an accepted request occupies W cycles, then result = a-b mod 2^W, borrow = a<b.
   int         rl8, rl1;
   logic       dm8, dm1, bm8, bm1, pb8, pb1;
   logic [7:0] rm8, pm8;
   logic [0:0] rm1, pm1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rl8 <= 0; dm8 <= 1'b0; rm8 <= '0; bm8 <= 1'b0; pm8 <= '0; pb8 <= 1'b0;
      end else if (rl8 > 0) begin
         rl8 <= rl8 - 1;
         dm8 <= (rl8 == 1);
         if (rl8 == 1) begin rm8 <= pm8; bm8 <= pb8; end
      end else begin
         dm8 <= 1'b0;
         if (st8) begin rl8 <= 8; pm8 <= a8 - b8; pb8 <= (a8 < b8); end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rl1 <= 0; dm1 <= 1'b0; rm1 <= '0; bm1 <= 1'b0; pm1 <= '0; pb1 <= 1'b0;
      end else if (rl1 > 0) begin
         rl1 <= rl1 - 1;
         dm1 <= (rl1 == 1);
         if (rl1 == 1) begin rm1 <= pm1; bm1 <= pb1; end
      end else begin
         dm1 <= 1'b0;
         if (st1) begin rl1 <= 1; pm1 <= a1 - b1; pb1 <= (a1 < b1); end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy8", 32'(busy8), 32'(rl8 > 0));
      chk("done8", 32'(done8), 32'(dm8));
      if (rl8 == 0) begin
         chk("diff8_hold", 32'(diff8), 32'(rm8));
         chk("bor8_hold", 32'(bor8), 32'(bm8));
         chk("fs8_idle", 32'({fa8, fb8, fbin8}), 32'd0);
      end
      chk("busy1", 32'(busy1), 32'(rl1 > 0));
      chk("done1", 32'(done1), 32'(dm1));
      if (rl1 == 0) begin
         chk("diff1_hold", 32'(diff1), 32'(rm1));
         chk("bor1_hold", 32'(bor1), 32'(bm1));
         chk("fs1_idle", 32'({fa1, fb1, fbin1}), 32'd0);
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] d, input logic br);
      int n;
      st8 = 1'b1; a8 = a; b8 = b;
      @(negedge clk);
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      n = 1;
      while (!done8 && n < 40) begin @(negedge clk); n++; end
      chk("lat8", 32'(n), 32'd9);
      chk("res8", 32'(diff8), 32'(d));
      chk("brw8", 32'(bor8), 32'(br));
   endtask

   task automatic op1(input logic a, input logic b, input logic d, input logic br);
      int n;
      st1 = 1'b1; a1 = a; b1 = b;
      @(negedge clk);
      st1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
      n = 1;
      while (!done1 && n < 20) begin @(negedge clk); n++; end
      chk("lat1", 32'(n), 32'd2);
      chk("res1", 32'(diff1), 32'(d));
      chk("brw1", 32'(bor1), 32'(br));
   endtask

   initial begin
      rst_n = 1'b0;
      st8 = 1'b0; a8 = '0; b8 = '0;
      st1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_outs8", 32'({diff8, bor8, busy8, done8, fa8, fb8, fbin8}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      op8(8'd200, 8'd55, 8'd145, 1'b0);
      @(negedge clk);
      op8(8'd5, 8'd9, 8'hFC, 1'b1);
      op8(8'd0, 8'd1, 8'd255, 1'b1);
      op8(8'd255, 8'd255, 8'd0, 1'b0);
      repeat (2) @(negedge clk);

      // start held: only the idle/done-cycle operands may be taken
      st8 = 1'b1; a8 = 8'd100; b8 = 8'd1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin a8 = 8'd7; b8 = 8'd3; end
         if (n == 9) begin
            chk("hold_done1", 32'(done8), 32'd1);
            chk("hold_res1", 32'(diff8), 32'd99);
            a8 = 8'd50; b8 = 8'd60;
         end
         if (n == 18) begin
            chk("hold_done2", 32'(done8), 32'd1);
            chk("hold_res2", 32'(diff8), 32'd246);
            chk("hold_brw2", 32'(bor8), 32'd1);
            a8 = 8'd1; b8 = 8'd1;
         end
      end
      st8 = 1'b0;
      repeat (12) @(negedge clk);

      // reset in the middle of a run
      st8 = 1'b1; a8 = 8'd17; b8 = 8'd3;
      @(negedge clk);
      st8 = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("midrst8", 32'({diff8, bor8, busy8, done8, fa8, fb8, fbin8}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      op8(8'd17, 8'd3, 8'd14, 1'b0);

      // back-to-back: second start lands in the done cycle
      @(negedge clk);
      op8(8'd30, 8'd10, 8'd20, 1'b0);
      op8(8'd10, 8'd20, 8'd246, 1'b1);
      repeat (3) @(negedge clk);

      op1(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      op1(1'b0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      op1(1'b1, 1'b1, 1'b0, 1'b0);
      op1(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
